// File: rtl/freq_note_decoder_if.sv
// -----------------------------------------------------------------------------
// freq_note_decoder_if
//   Request/result bundle for freq_note_decoder.
//
//   Handshake: the requester drives freq and pulses freq_valid. The decoder
//   takes the request only on a rising edge where busy=0. A freq_valid seen
//   while busy=1 is dropped and is not queued. Each accepted request gives
//   exactly one code_valid pulse, one cycle wide. code, exact and out_of_range
//   update in that cycle and then hold until the next pulse.
//
//   Signals:
//     freq          requester -> decoder  frequency in Hz, unsigned
//     freq_valid    requester -> decoder  request strobe
//     busy          decoder -> requester  engine not idle
//     code          decoder -> requester  switch code {oct[1:0], acc, note[2:0]}
//     code_valid    decoder -> requester  one-cycle result strobe
//     exact         decoder -> requester  normalised frequency hit a table entry
//     out_of_range  decoder -> requester  input lies outside octaves 3..6
// -----------------------------------------------------------------------------
interface freq_note_decoder_if #(
  parameter int FREQ_W = 12
);
  logic [FREQ_W-1:0] freq;
  logic              freq_valid;
  logic              busy;
  logic [5:0]        code;
  logic              code_valid;
  logic              exact;
  logic              out_of_range;

  modport master (
    output freq, freq_valid,
    input  busy, code, code_valid, exact, out_of_range
  );

  modport slave (
    input  freq, freq_valid,
    output busy, code, code_valid, exact, out_of_range
  );
endinterface

// File: rtl/freq_note_decoder.sv
// -----------------------------------------------------------------------------
// freq_note_decoder
//   This block is the inverse of the switch-to-frequency note encoder. It
//   takes a frequency in Hz and returns the nearest switch-format note code:
//   {octave[1:0], accidental, note[2:0]}.
//
//   The engine is iterative:
//     NORM   Shift the frequency by one octave per cycle until it falls in the
//            octave-4 window [254, 508). Out-of-range inputs are rejected in
//            the first NORM cycle.
//     SEARCH Scan the 12-entry octave-4 table, one entry per cycle, and keep
//            the closest entry. A tie keeps the lower note.
//     DONE   Register the result. code_valid goes high in the following cycle.
//
//   Latency from the accepting edge to the cycle in which code_valid is high:
//   14+k cycles for in-range inputs, where k is the number of shifts, and
//   2 cycles for out-of-range inputs.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   bus          slave modport of freq_note_decoder_if (request/result)
//   o_dbg_state  out  current FSM state (IDLE=0, NORM=1, SEARCH=2, DONE=3)
//
// FREQ_W must be at least 12. After normalisation the value is below 508,
// so the distance arithmetic runs on the low 12 bits.
// -----------------------------------------------------------------------------
module freq_note_decoder #(
  parameter int         FREQ_W       = 12,
  parameter logic [5:0] DEFAULT_CODE = 6'b000101
) (
  input  logic                       clk,
  input  logic                       rst_n,
  freq_note_decoder_if.slave         bus,
  output logic [1:0]                 o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NORM   = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Accepted range is 127..2031. The top of the range normalises to 507
  // after two right shifts. The bottom normalises to 254 after one left shift.
  localparam logic [FREQ_W-1:0] LO_LIMIT  = FREQ_W'(127);
  localparam logic [FREQ_W-1:0] HI_LIMIT  = FREQ_W'(2032);
  localparam logic [FREQ_W-1:0] WIN_LO    = FREQ_W'(254);
  localparam logic [FREQ_W-1:0] WIN_HI    = FREQ_W'(508);
  localparam logic [3:0]        LAST_IDX  = 4'd11;

  state_t            r_state;
  logic [FREQ_W-1:0] r_f;
  logic [1:0]        r_oct;        // octave-4 in 2-bit two's complement: 4=00 5=01 6=10 3=11
  logic              r_first;      // first NORM cycle, where the range check happens
  logic              r_oor;        // the pending result is out of range
  logic [3:0]        r_idx;
  logic [3:0]        r_best_idx;
  logic [11:0]       r_best_dist;
  logic [5:0]        r_code;
  logic              r_code_valid;
  logic              r_exact;
  logic              r_out_of_range;

  // Octave-4 reference table, in Hz.
  function automatic logic [11:0] table_freq(input logic [3:0] idx);
    logic [11:0] v;
    case (idx)
      4'd0:    v = 12'd261;
      4'd1:    v = 12'd277;
      4'd2:    v = 12'd293;
      4'd3:    v = 12'd311;
      4'd4:    v = 12'd330;
      4'd5:    v = 12'd349;
      4'd6:    v = 12'd370;
      4'd7:    v = 12'd392;
      4'd8:    v = 12'd415;
      4'd9:    v = 12'd440;
      4'd10:   v = 12'd466;
      4'd11:   v = 12'd494;
      default: v = 12'd0;
    endcase
    return v;
  endfunction

  // Lower four bits of the switch code for each entry: {acc, note[2:0]}.
  function automatic logic [3:0] table_code(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:    v = 4'b0_000; // C
      4'd1:    v = 4'b1_000; // C#
      4'd2:    v = 4'b0_001; // D
      4'd3:    v = 4'b1_001; // D#
      4'd4:    v = 4'b0_010; // E
      4'd5:    v = 4'b0_011; // F
      4'd6:    v = 4'b1_011; // F#
      4'd7:    v = 4'b0_100; // G
      4'd8:    v = 4'b1_100; // G#
      4'd9:    v = 4'b0_101; // A
      4'd10:   v = 4'b1_101; // A#
      4'd11:   v = 4'b0_110; // B
      default: v = 4'b0_000;
    endcase
    return v;
  endfunction

  logic [11:0] w_f12;
  logic [11:0] w_entry;
  logic [11:0] w_dist;
  logic        w_range_bad;

  assign w_f12       = r_f[11:0];
  assign w_entry     = table_freq(r_idx);
  assign w_dist      = (w_f12 >= w_entry) ? (w_f12 - w_entry) : (w_entry - w_f12);
  assign w_range_bad = (r_f < LO_LIMIT) || (r_f >= HI_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_f            <= '0;
      r_oct          <= 2'b00;
      r_first        <= 1'b0;
      r_oor          <= 1'b0;
      r_idx          <= 4'd0;
      r_best_idx     <= 4'd0;
      r_best_dist    <= '1;
      r_code         <= DEFAULT_CODE;
      r_code_valid   <= 1'b0;
      r_exact        <= 1'b0;
      r_out_of_range <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.freq_valid) begin
            r_f         <= bus.freq;
            r_oct       <= 2'b00;
            r_first     <= 1'b1;
            r_oor       <= 1'b0;
            r_idx       <= 4'd0;
            r_best_idx  <= 4'd0;
            r_best_dist <= '1;
            r_state     <= S_NORM;
          end
        end

        S_NORM: begin
          r_first <= 1'b0;
          if (r_first && w_range_bad) begin
            r_oor   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_f >= WIN_HI) begin
            r_f   <= r_f >> 1;
            r_oct <= r_oct + 2'd1;
          end else if (r_f < WIN_LO) begin
            r_f   <= r_f << 1;
            r_oct <= r_oct - 2'd1;
          end else begin
            r_state <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          // Strict less-than: on equal distance the earlier, lower note stays.
          if (w_dist < r_best_dist) begin
            r_best_dist <= w_dist;
            r_best_idx  <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end

        S_DONE: begin
          r_code_valid <= 1'b1;
          if (r_oor) begin
            r_code         <= DEFAULT_CODE;
            r_exact        <= 1'b0;
            r_out_of_range <= 1'b1;
          end else begin
            r_code         <= {r_oct, table_code(r_best_idx)};
            r_exact        <= (r_best_dist == 12'd0);
            r_out_of_range <= 1'b0;
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.code         = r_code;
  assign bus.code_valid   = r_code_valid;
  assign bus.exact        = r_exact;
  assign bus.out_of_range = r_out_of_range;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_freq_note_decoder.sv
// -----------------------------------------------------------------------------
// tb_freq_note_decoder
//   Directed testbench for freq_note_decoder. Every expected code, latency and
//   flag value below was worked out by hand from the note table and the
//   octave normalisation rules. Inputs change and outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_freq_note_decoder;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] f;
    logic [5:0]  code;
    logic        ex;
    logic        oor;
    int          lat;
  } vec_t;

  freq_note_decoder_if #(.FREQ_W(12)) bus ();

  freq_note_decoder #(.FREQ_W(12), .DEFAULT_CODE(6'b000101)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- driver
  // Issues one request at a falling edge. The request is taken on the next
  // rising edge. lat counts rising edges from the accepting edge up to the
  // cycle in which code_valid is seen high.
  task automatic send_req(input logic [11:0] f, output int lat, output bit got);
    @(negedge clk);
    bus.freq       = f;
    bus.freq_valid = 1'b1;
    @(negedge clk);
    bus.freq_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (bus.code_valid === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    bus.freq = '0;
    bus.freq_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.code !== 6'b000101) begin errors++; $display("FAIL reset_code: got %b expected 000101", bus.code); end
    checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL reset_code_valid: got %b expected 0", bus.code_valid); end
    checks++; if (bus.exact !== 1'b0) begin errors++; $display("FAIL reset_exact: got %b expected 0", bus.exact); end
    checks++; if (bus.out_of_range !== 1'b0) begin errors++; $display("FAIL reset_oor: got %b expected 0", bus.out_of_range); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact_octaves();
    vec_t tab[4];
    int lat;
    bit got;
    tab[0] = '{12'd440,  6'b000101, 1'b1, 1'b0, 14}; // A4, no shift
    tab[1] = '{12'd880,  6'b010101, 1'b1, 1'b0, 15}; // A5, one right shift
    tab[2] = '{12'd1976, 6'b100110, 1'b1, 1'b0, 16}; // B6, two right shifts
    tab[3] = '{12'd1568, 6'b100100, 1'b1, 1'b0, 16}; // G6 -> 392
    for (int i = 0; i < 4; i++) begin
      send_req(tab[i].f, lat, got);
      checks++; if (!got) begin errors++; $display("FAIL exact_timeout f=%0d: no code_valid within 40 cycles", tab[i].f); end
      checks++; if (lat != tab[i].lat) begin errors++; $display("FAIL exact_latency f=%0d: got %0d expected %0d", tab[i].f, lat, tab[i].lat); end
      checks++; if (bus.code !== tab[i].code) begin errors++; $display("FAIL exact_code f=%0d: got %b expected %b", tab[i].f, bus.code, tab[i].code); end
      checks++; if (bus.exact !== tab[i].ex) begin errors++; $display("FAIL exact_flag f=%0d: got %b expected %b", tab[i].f, bus.exact, tab[i].ex); end
      checks++; if (bus.out_of_range !== tab[i].oor) begin errors++; $display("FAIL exact_oor f=%0d: got %b expected %b", tab[i].f, bus.out_of_range, tab[i].oor); end
      @(negedge clk);
      checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL exact_pulse_width f=%0d: code_valid still %b, expected 0", tab[i].f, bus.code_valid); end
      checks++; if (bus.code !== tab[i].code) begin errors++; $display("FAIL exact_hold f=%0d: got %b expected %b", tab[i].f, bus.code, tab[i].code); end
    end
  endtask

  task automatic test_nearest();
    vec_t tab[5];
    int lat;
    bit got;
    tab[0] = '{12'd130,  6'b110000, 1'b0, 1'b0, 15}; // 260 -> C3, dist 1
    tab[1] = '{12'd269,  6'b000000, 1'b0, 1'b0, 14}; // tie 261/277 -> lower C
    tab[2] = '{12'd127,  6'b110000, 1'b0, 1'b0, 15}; // lowest in range: 254 -> C3
    tab[3] = '{12'd2031, 6'b100110, 1'b0, 1'b0, 16}; // highest in range: 507 -> B6
    tab[4] = '{12'd300,  6'b000001, 1'b0, 1'b0, 14}; // D (7) beats D# (11)
    for (int i = 0; i < 5; i++) begin
      send_req(tab[i].f, lat, got);
      checks++; if (!got) begin errors++; $display("FAIL near_timeout f=%0d: no code_valid within 40 cycles", tab[i].f); end
      checks++; if (lat != tab[i].lat) begin errors++; $display("FAIL near_latency f=%0d: got %0d expected %0d", tab[i].f, lat, tab[i].lat); end
      checks++; if (bus.code !== tab[i].code) begin errors++; $display("FAIL near_code f=%0d: got %b expected %b", tab[i].f, bus.code, tab[i].code); end
      checks++; if (bus.exact !== tab[i].ex) begin errors++; $display("FAIL near_exact f=%0d: got %b expected %b", tab[i].f, bus.exact, tab[i].ex); end
      checks++; if (bus.out_of_range !== tab[i].oor) begin errors++; $display("FAIL near_oor f=%0d: got %b expected %b", tab[i].f, bus.out_of_range, tab[i].oor); end
      @(negedge clk);
    end
  endtask

  task automatic test_out_of_range();
    logic [11:0] ftab[5];
    int lat;
    bit got;
    ftab = '{12'd100, 12'd2040, 12'd0, 12'd126, 12'd2032};
    for (int i = 0; i < 5; i++) begin
      send_req(ftab[i], lat, got);
      checks++; if (!got) begin errors++; $display("FAIL oor_timeout f=%0d: no code_valid within 40 cycles", ftab[i]); end
      checks++; if (lat != 2) begin errors++; $display("FAIL oor_latency f=%0d: got %0d expected 2", ftab[i], lat); end
      checks++; if (bus.code !== 6'b000101) begin errors++; $display("FAIL oor_code f=%0d: got %b expected 000101", ftab[i], bus.code); end
      checks++; if (bus.exact !== 1'b0) begin errors++; $display("FAIL oor_exact f=%0d: got %b expected 0", ftab[i], bus.exact); end
      checks++; if (bus.out_of_range !== 1'b1) begin errors++; $display("FAIL oor_flag f=%0d: got %b expected 1", ftab[i], bus.out_of_range); end
      @(negedge clk);
    end
  endtask

  task automatic test_dropped_request();
    int  lat;
    bit  got;
    bit  busy_low_seen;
    int  extra;
    @(negedge clk);
    bus.freq       = 12'd466;
    bus.freq_valid = 1'b1;
    @(negedge clk);
    bus.freq_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    busy_low_seen = 1'b0;
    while (!got && lat < 40) begin
      if (bus.code_valid === 1'b1) got = 1'b1;
      else begin
        if (bus.busy !== 1'b1) busy_low_seen = 1'b1;
        if (lat == 5) begin
          bus.freq       = 12'd261;
          bus.freq_valid = 1'b1;
        end else begin
          bus.freq_valid = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    bus.freq_valid = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL drop_timeout: no code_valid within 40 cycles"); end
    checks++; if (lat != 14) begin errors++; $display("FAIL drop_latency: got %0d expected 14", lat); end
    checks++; if (busy_low_seen) begin errors++; $display("FAIL drop_busy: busy went low before the result, expected high"); end
    checks++; if (bus.code !== 6'b001101) begin errors++; $display("FAIL drop_code: got %b expected 001101", bus.code); end
    checks++; if (bus.exact !== 1'b1) begin errors++; $display("FAIL drop_exact: got %b expected 1", bus.exact); end
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.code_valid === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL drop_second_result: got %0d extra pulses expected 0", extra); end
    checks++; if (bus.code !== 6'b001101) begin errors++; $display("FAIL drop_code_hold: got %b expected 001101", bus.code); end
  endtask

  task automatic test_reset_mid_search();
    int lat;
    bit got;
    int pulses;
    @(negedge clk);
    bus.freq       = 12'd1976;
    bus.freq_valid = 1'b1;
    @(negedge clk);
    bus.freq_valid = 1'b0;
    // Accepting edge, two shift cycles, then SEARCH from the fourth edge on.
    repeat (5) @(negedge clk);
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL midrst_in_search: state %0d expected 2", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.code !== 6'b000101) begin errors++; $display("FAIL midrst_code: got %b expected 000101", bus.code); end
    checks++; if (bus.exact !== 1'b0) begin errors++; $display("FAIL midrst_exact: got %b expected 0", bus.exact); end
    checks++; if (bus.out_of_range !== 1'b0) begin errors++; $display("FAIL midrst_oor: got %b expected 0", bus.out_of_range); end
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.code_valid === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.code_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses); end
    send_req(12'd880, lat, got);
    checks++; if (!got) begin errors++; $display("FAIL midrst_after_timeout: no code_valid within 40 cycles"); end
    checks++; if (lat != 15) begin errors++; $display("FAIL midrst_after_latency: got %0d expected 15", lat); end
    checks++; if (bus.code !== 6'b010101) begin errors++; $display("FAIL midrst_after_code: got %b expected 010101", bus.code); end
    checks++; if (bus.exact !== 1'b1) begin errors++; $display("FAIL midrst_after_exact: got %b expected 1", bus.exact); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t;
    int first_t;
    int second_t;
    logic [5:0] first_code;
    // freq_valid held high: each request is taken in the first IDLE cycle
    // after the previous result, so pulses arrive every latency+1 cycles.
    @(negedge clk);
    bus.freq       = 12'd293;
    bus.freq_valid = 1'b1;
    t = 0;
    first_t = -1;
    second_t = -1;
    first_code = '0;
    while (second_t < 0 && t < 80) begin
      @(negedge clk);
      t++;
      if (bus.code_valid === 1'b1) begin
        if (first_t < 0) begin
          first_t = t;
          first_code = bus.code;
        end else begin
          second_t = t;
        end
      end
    end
    bus.freq_valid = 1'b0;
    checks++; if (second_t < 0) begin errors++; $display("FAIL b2b_timeout: second result missing after %0d cycles", t); end
    checks++; if (first_t != 15) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 15", first_t); end
    checks++; if (second_t - first_t != 15) begin errors++; $display("FAIL b2b_interval: got %0d expected 15", second_t - first_t); end
    checks++; if (first_code !== 6'b000001) begin errors++; $display("FAIL b2b_code0: got %b expected 000001", first_code); end
    checks++; if (bus.code !== 6'b000001) begin errors++; $display("FAIL b2b_code1: got %b expected 000001", bus.code); end
    repeat (20) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: busy %b expected 0", bus.busy); end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    rst_n = 1'b0;
    bus.freq = '0;
    bus.freq_valid = 1'b0;
    test_reset();
    test_exact_octaves();
    test_nearest();
    test_out_of_range();
    test_dropped_request();
    test_reset_mid_search();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
